// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding, phase lengths and line-drive decode for the I2C write master
package i2c_pkg;
  typedef enum logic [2:0] {IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP} state_t;
  localparam logic RW_WRITE = 1'b0;
  localparam int Q_START = 2;
  localparam int Q_BIT = 4;
  localparam int Q_STOP = 3;
  function automatic logic [1:0] last_qtr(state_t s);
    return s == START ? 2'(Q_START - 1) : s == STOP ? 2'(Q_STOP - 1) : 2'(Q_BIT - 1);
  endfunction
  function automatic logic [1:0] drive(state_t s, logic [1:0] q, logic b);
    case (s)
      START:              return {1'b0, q == 2'd1};
      ADDR, DATA:         return {q < 2'd2, ~b};
      ADDR_ACK, DATA_ACK: return {q < 2'd2, 1'b0};
      STOP:               return {q == 2'd0, q != 2'd2};
      default:            return 2'b00;
    endcase
  endfunction
  function automatic logic stretch_win(state_t s, logic [1:0] q);
    return s == STOP ? q == 2'd1 : (s inside {ADDR, ADDR_ACK, DATA, DATA_ACK}) && q[1];
  endfunction
endpackage

// File: rtl/i2c_quarter_tick.sv
// i2c_quarter_tick: one-cycle tick every CLK_DIV enabled cycles; frozen by hold, cleared when disabled
module i2c_quarter_tick #(
  parameter int CLK_DIV = 125
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic hold,
  output logic tick
);
  logic [15:0] cnt_q, cnt_d;
  assign tick = en && !hold && cnt_q == 16'(CLK_DIV - 1);
  // next count: restart when idle or on wrap, freeze while held
  always_comb cnt_d = !en ? '0 : hold ? cnt_q : tick ? '0 : cnt_q + 16'd1;
  // counter register
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/i2c_master_wr.sv
// i2c_master_wr: single-byte I2C write master; clock stretching enabled by defining I2C_MASTER_WR_CLKSTRETCH_EN
module i2c_master_wr
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] dev_addr,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_i,
  input  logic       sda_i
);
  state_t state_q, state_d;
  logic [1:0] qtr_q, qtr_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, data_q, data_d;
  logic ack_err_q, ack_err_d, done_q, done_d;
  logic scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
  logic tick, hold, last;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign ack_err = ack_err_q;
  assign scl_oe = scl_oe_q;
  assign sda_oe = sda_oe_q;
`ifdef I2C_MASTER_WR_CLKSTRETCH_EN
  assign hold = !scl_i && stretch_win(state_q, qtr_q);
`else
  logic unused_scl;
  assign unused_scl = scl_i;
  assign hold = 1'b0;
`endif
  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk(clk),
    .rst(rst),
    .en(busy),
    .hold(hold),
    .tick(tick)
  );
  // next-state: advance quarters on ticks, move phases on the last quarter, decode line drive from next state
  always_comb begin
    state_d = state_q;
    qtr_d = qtr_q;
    bit_d = bit_q;
    shift_d = shift_q;
    data_d = data_q;
    ack_err_d = ack_err_q;
    done_d = 1'b0;
    last = tick && qtr_q == last_qtr(state_q);
    if (state_q == IDLE) begin
      if (start) begin
        state_d = START;
        qtr_d = 2'd0;
        bit_d = 3'd0;
        shift_d = {dev_addr, RW_WRITE};
        data_d = data;
        ack_err_d = 1'b0;
      end
    end else if (tick) begin
      qtr_d = last ? 2'd0 : qtr_q + 2'd1;
      if (last)
        case (state_q)
          START: state_d = ADDR;
          ADDR, DATA: begin
            shift_d = {shift_q[6:0], 1'b0};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = state_q == ADDR ? ADDR_ACK : DATA_ACK;
          end
          ADDR_ACK: begin
            ack_err_d = sda_i;
            state_d = sda_i ? STOP : DATA;
            shift_d = data_q;
          end
          DATA_ACK: begin
            ack_err_d = sda_i;
            state_d = STOP;
          end
          STOP: begin
            state_d = IDLE;
            done_d = 1'b1;
          end
          default: state_d = IDLE;
        endcase
    end
    {scl_oe_d, sda_oe_d} = drive(state_d, qtr_d, shift_d[7]);
  end
  // state and registered line drivers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      qtr_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      ack_err_q <= 1'b0;
      done_q <= 1'b0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      qtr_q <= qtr_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      data_q <= data_d;
      ack_err_q <= ack_err_d;
      done_q <= done_d;
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
    end
  end
endmodule

// File: tb/tb_i2c_master_wr.sv
// tb_i2c_master_wr: directed write transactions against a small open-drain bus and slave model
module tb_i2c_master_wr;
  localparam int CLK_DIV = 4;
`ifdef I2C_MASTER_WR_CLKSTRETCH_EN
  localparam int EXP_STRETCH = 20;
`else
  localparam int EXP_STRETCH = 0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [6:0] dev_addr = '0;
  logic [7:0] data = '0;
  logic busy, done, ack_err, scl_oe, sda_oe, scl_i, sda_i;
  logic pull = 1'b0, stretch = 1'b0, ack_a = 1'b1, ack_d = 1'b1;
  logic prev_scl = 1'b1, prev_sda = 1'b1, sda_now;
  logic [7:0] rx_addr = '0, rx_data = '0;
  int edges = 0, stops = 0, dones = 0;
  int total = 0, bad = 0;
  int cyc;
  logic busy1, ae5, aborted;

  assign scl_i = ~scl_oe & ~stretch;
  assign sda_i = ~sda_oe & ~pull;

  always #5 clk = ~clk;

  i2c_master_wr #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .dev_addr(dev_addr), .data(data),
    .busy(busy), .done(done), .ack_err(ack_err), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .scl_i(scl_i), .sda_i(sda_i)
  );

  // slave/bus monitor on the falling clock edge: capture bits, drive ACK, count STOPs and done pulses
  always @(negedge clk) begin
    sda_now = ~sda_oe & ~pull;
    if (start && !busy) begin
      edges = 0; rx_addr = '0; rx_data = '0; stops = 0; dones = 0; pull = 1'b0;
    end else begin
      if (!prev_scl && !scl_oe) begin
        edges++;
        if (edges <= 8) rx_addr = {rx_addr[6:0], sda_now};
        else if (edges >= 10 && edges <= 17) rx_data = {rx_data[6:0], sda_now};
      end
      if (prev_scl && scl_oe) pull = (edges == 8 && ack_a) || (edges == 17 && ack_d);
      if (!scl_oe && !prev_sda && sda_now) stops++;
      if (done) dones++;
    end
    prev_scl = ~scl_oe;
    prev_sda = ~sda_oe & ~pull;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [6:0] a, input logic [7:0] d, input logic aa, input logic ad,
                     input int restart_at, input int rst_at, input int stretch_at);
    ack_a = aa; ack_d = ad;
    @(negedge clk);
    dev_addr = a; data = d; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; busy1 = 1'b0; ae5 = 1'b1; aborted = 1'b0;
    while (cyc < 3000) begin
      @(posedge clk);
      #1 cyc++;
      if (done) break;
      if (cyc == 1) busy1 = busy;
      if (cyc == 5) ae5 = ack_err;
      start = (cyc == restart_at);
      if (start) begin dev_addr = ~a; data = ~d; end
      if (cyc == stretch_at) stretch = 1'b1;
      if (cyc == stretch_at + 20) stretch = 1'b0;
      if (cyc == rst_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_scl_oe", scl_oe, 0);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        aborted = 1'b1;
        break;
      end
    end
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ack_err", ack_err, 0);
    chk("reset_scl_oe", scl_oe, 0);
    chk("reset_sda_oe", sda_oe, 0);
    rst = 1'b0;

    run(7'h3C, 8'hA5, 1'b1, 1'b1, 0, 0, 0);
    chk("t1_cycles", cyc, 308);
    chk("t1_busy_rise", busy1, 1);
    chk("t1_ack_err", ack_err, 0);
    chk("t1_addr_byte", rx_addr, 8'h78);
    chk("t1_data_byte", rx_data, 8'hA5);
    chk("t1_scl_edges", edges, 19);
    chk("t1_stops", stops, 1);
    chk("t1_dones", dones, 1);
    chk("t1_idle_busy", busy, 0);

    run(7'h3C, 8'hA5, 1'b0, 1'b0, 0, 0, 0);
    chk("t2_cycles", cyc, 164);
    chk("t2_ack_err", ack_err, 1);
    chk("t2_scl_edges", edges, 10);
    chk("t2_data_byte", rx_data, 8'h00);
    chk("t2_stops", stops, 1);
    chk("t2_dones", dones, 1);

    run(7'h3C, 8'hA5, 1'b1, 1'b0, 0, 0, 0);
    chk("t3_cycles", cyc, 308);
    chk("t3_ack_err", ack_err, 1);
    chk("t3_data_byte", rx_data, 8'hA5);

    run(7'h3C, 8'hA5, 1'b1, 1'b1, 10, 0, 0);
    chk("t4_ack_err_cleared", ae5, 0);
    chk("t4_cycles", cyc, 308);
    chk("t4_addr_byte", rx_addr, 8'h78);
    chk("t4_data_byte", rx_data, 8'hA5);
    chk("t4_dones", dones, 1);
    chk("t4_ack_err", ack_err, 0);

    run(7'h12, 8'h34, 1'b1, 1'b1, 0, 100, 0);
    chk("t5_aborted", aborted, 1);
    chk("t5_dones", dones, 0);
    chk("t5_idle_busy", busy, 0);

    run(7'h5A, 8'hC3, 1'b1, 1'b1, 0, 0, 0);
    chk("t6_cycles", cyc, 308);
    chk("t6_addr_byte", rx_addr, 8'hB4);
    chk("t6_data_byte", rx_data, 8'hC3);
    chk("t6_ack_err", ack_err, 0);

    run(7'h3C, 8'hA5, 1'b1, 1'b1, 0, 0, 17);
    chk("t7_cycles", cyc, 308 + EXP_STRETCH);
    chk("t7_addr_byte", rx_addr, 8'h78);
    chk("t7_data_byte", rx_data, 8'hA5);
    chk("t7_dones", dones, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2c_master_wr.md
I2C_MASTER_WR -- requirements
Module: i2c_master_wr

Interface
REQ-001 SHALL have parameter CLK_DIV, default 125, the number of clk cycles per quarter SCL period; legal values are 2 to 65535.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: a one-cycle request to begin a write transaction.
REQ-005 SHALL have port dev_addr, input, 7 bits: the 7-bit target address, captured when start is accepted.
REQ-006 SHALL have port data, input, 8 bits: the byte to write (for example a 4-bit display nibble in bits 3:0), captured when start is accepted.
REQ-007 SHALL have port busy, output, 1 bit: high while a transaction is in progress.
REQ-008 SHALL have port done, output, 1 bit: a one-cycle pulse when a transaction completes.
REQ-009 SHALL have port ack_err, output, 1 bit: NACK status of the last transaction, valid from done until the next start is accepted.
REQ-010 SHALL have port scl_oe, output, 1 bit: 1 pulls SCL low, 0 releases it.
REQ-011 SHALL have port sda_oe, output, 1 bit: 1 pulls SDA low, 0 releases it.
REQ-012 SHALL have port scl_i, input, 1 bit: sampled SCL line level.
REQ-013 SHALL have port sda_i, input, 1 bit: sampled SDA line level.

Function
REQ-014 SHALL generate a quarter tick every CLK_DIV clk cycles while busy; the tick counter SHALL restart at 0 on start acceptance.
REQ-015 SHALL accept start only in IDLE; a start pulse while busy SHALL be ignored and SHALL NOT disturb the captured dev_addr or data.
REQ-016 SHALL implement the states IDLE -> START -> ADDR -> ADDR_ACK -> DATA -> DATA_ACK -> STOP -> IDLE.
REQ-017 START SHALL last 2 quarters: q0 with SCL and SDA released; q1 with SDA low and SCL released.
REQ-018 ADDR SHALL send the 8 bits {dev_addr, 1'b0}, MSB first; DATA SHALL send data, MSB first.
REQ-019 Each bit SHALL last 4 quarters: SDA is updated at the start of q0; SCL is low in q0 and q1 and released in q2 and q3.
REQ-020 ADDR_ACK and DATA_ACK SHALL each last 4 quarters with SDA released; sda_i SHALL be sampled on the last clk of q3, where 1 means NACK.
REQ-021 A NACK in ADDR_ACK SHALL set ack_err and go to STOP, skipping DATA.
REQ-022 A NACK in DATA_ACK SHALL set ack_err; an ACK SHALL leave ack_err at 0.
REQ-023 STOP SHALL last 3 quarters: q0 with SCL low and SDA low; q1 with SCL released and SDA low; q2 with both released.
REQ-024 done SHALL pulse for one cycle as the state returns to IDLE; busy SHALL fall in that same cycle.
REQ-025 busy SHALL rise in the cycle after start is accepted.
REQ-026 Total duration SHALL be 77 quarters (77*CLK_DIV cycles) for an ACKed transaction and 41 quarters when the address is NACKed.
REQ-027 ack_err SHALL clear to 0 on start acceptance.

Reset
REQ-028 On rst, all of the following SHALL hold from the next edge: state is IDLE, the tick counter and bit counter are 0, scl_oe, sda_oe, busy, done and ack_err are 0.
REQ-029 Asserting rst mid-transaction SHALL abort the transaction without generating a STOP and without pulsing done.

Configuration
REQ-030 With I2C_MASTER_WR_CLKSTRETCH_EN defined, the quarter counter SHALL hold during q2 and q3 of any bit, ACK or STOP-q1 quarter while scl_i is 0, then resume when scl_i returns to 1.
REQ-031 Without I2C_MASTER_WR_CLKSTRETCH_EN, scl_i SHALL be ignored, the port SHALL remain present, and timing SHALL be fixed per REQ-026.

Structure
REQ-032 The shared package i2c_pkg SHALL hold the state enumeration, the RW_WRITE constant (1'b0), and the quarter counts per phase (2, 4 and 3).
REQ-033 The quarter-tick generator SHALL be the sub-module i2c_quarter_tick, with inputs clk, rst, en and hold and output tick.

Verification
REQ-034 With CLK_DIV=4, start, dev_addr=0x3C, data=0xA5 and the slave ACKing: SDA bits 0x78 and then 0xA5 are observed at SCL rising edges, done arrives 308 cycles after acceptance, and ack_err=0.
REQ-035 Same stimulus with sda_i held at 1: done arrives after 164 cycles, ack_err=1, no data byte appears on SDA, and a STOP is observed.
REQ-036 ACK on address and NACK on data: done arrives after 308 cycles with ack_err=1.
REQ-037 A second start pulse 10 cycles into a transaction is ignored: the transmitted bytes are unchanged and exactly one done pulse occurs.
REQ-038 rst asserted at cycle 100 of a transaction: the next cycle has scl_oe=0, sda_oe=0, busy=0 and no done; a new start then completes normally.
REQ-039 With the macro defined, scl_i forced to 0 for 20 cycles during an ADDR bit: done is delayed by exactly 20 cycles; without the macro the delay is 0.
